// File: rtl/six_bit_one_to_three_demux_reg_module_pkg.sv
// Shared definitions for the 6-bit 1:3 registered demux: select encoding,
// default widths and a small saturating-increment helper.
package six_bit_one_to_three_demux_reg_module_pkg;

  localparam int unsigned WIDTH_DEF = 6;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned NUM_CH    = 3;

  // Destination select; SEL_BAD words are accepted and dropped.
  typedef enum logic [1:0] {
    SEL_CH0 = 2'd0,
    SEL_CH1 = 2'd1,
    SEL_CH2 = 2'd2,
    SEL_BAD = 2'd3
  } sel_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W_DEF-1:0] sat_inc8(input logic [CNT_W_DEF-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/six_bit_one_to_three_demux_reg_module_slot.sv
// One-entry output slot: holds a single word with its valid flag.
// Load wins over drain, so load + drain in one cycle replaces the word
// without a bubble.
module six_bit_out_slot_module #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // Next-state: load takes priority; otherwise a drain clears valid.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/six_bit_one_to_three_demux_reg_module.sv
// 6-bit 1:3 registered demux. Steers an input word to one of three
// one-entry output slots by in_sel; sel=3 words are dropped, flagged on
// err_pulse one cycle later and counted in a saturating drop counter.
module six_bit_one_to_three_demux_reg_module
  import six_bit_one_to_three_demux_reg_module_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic             out0_valid,
  output logic             out1_valid,
  output logic             out2_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  input  logic             out2_ready,
  output logic             err_pulse,
  output logic [CNT_W-1:0] drop_cnt
);

  sel_e                sel;
  logic [NUM_CH-1:0]   ch_ready;
  logic [NUM_CH-1:0]   ch_valid;
  logic [NUM_CH-1:0]   ch_free;
  logic [NUM_CH-1:0]   load;
  logic                drop;
  logic [WIDTH-1:0]    ch_data [NUM_CH];

  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  assign sel      = sel_e'(in_sel);
  assign ch_ready = {out2_ready, out1_ready, out0_ready};
  // A slot can take a word if it is empty or being drained this cycle.
  assign ch_free  = ~ch_valid | ch_ready;

  // in_ready depends only on in_sel and the target slot; held low in reset.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      unique case (sel)
        SEL_CH0: in_ready = ch_free[0];
        SEL_CH1: in_ready = ch_free[1];
        SEL_CH2: in_ready = ch_free[2];
        SEL_BAD: in_ready = 1'b1;
      endcase
    end
  end

  // Select decode: one load strobe per slot plus the drop strobe.
  always_comb begin
    load = '0;
    drop = 1'b0;
    if (in_valid && in_ready) begin
      unique case (sel)
        SEL_CH0: load[0] = 1'b1;
        SEL_CH1: load[1] = 1'b1;
        SEL_CH2: load[2] = 1'b1;
        SEL_BAD: drop    = 1'b1;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    six_bit_out_slot_module #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[g]),
      .load_data (in_data),
      .ready     (ch_ready[g]),
      .valid     (ch_valid[g]),
      .data      (ch_data[g])
    );
  end

  assign out0_valid = ch_valid[0];
  assign out1_valid = ch_valid[1];
  assign out2_valid = ch_valid[2];
  assign out0_data  = ch_data[0];
  assign out1_data  = ch_data[1];
  assign out2_data  = ch_data[2];

  // Error pulse follows each accepted drop; counter saturates at all-ones.
  always_comb begin
    err_d = drop;
    cnt_d = cnt_q;
    if (drop && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Error/drop-count registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_pulse = err_q;
  assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_six_bit_one_to_three_demux_reg_module.sv
// Self-checking bench for the 6-bit 1:3 registered demux.
module tb_six_bit_one_to_three_demux_reg_module;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] out0_data, out1_data, out2_data;
  logic       out0_valid, out1_valid, out2_valid;
  logic [2:0] rdy;
  logic       err_pulse;
  logic [7:0] drop_cnt;

  logic [5:0] od [3];
  logic       ov [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: channel contents, pending error, drop total.
  bit         mv [3];
  logic [5:0] md [3];
  bit         merr;
  int         mcnt;

  always #5 clk = ~clk;

  six_bit_one_to_three_demux_reg_module #(
    .WIDTH (6),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out1_data  (out1_data),
    .out2_data  (out2_data),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid),
    .out2_valid (out2_valid),
    .out0_ready (rdy[0]),
    .out1_ready (rdy[1]),
    .out2_ready (rdy[2]),
    .err_pulse  (err_pulse),
    .drop_cnt   (drop_cnt)
  );

  assign od[0] = out0_data;
  assign od[1] = out1_data;
  assign od[2] = out2_data;
  assign ov[0] = out0_valid;
  assign ov[1] = out1_valid;
  assign ov[2] = out2_valid;

  function automatic bit m_ready();
    if (in_sel == 2'd3) return 1'b1;
    return !mv[in_sel] || rdy[in_sel];
  endfunction

  task automatic model_clear();
    for (int n = 0; n < 3; n++) begin
      mv[n] = 1'b0;
      md[n] = '0;
    end
    merr = 1'b0;
    mcnt = 0;
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit acc;
    acc = in_valid && m_ready();
    for (int n = 0; n < 3; n++) begin
      if (acc && in_sel == n) begin
        mv[n] = 1'b1;
        md[n] = in_data;
      end else if (mv[n] && rdy[n]) begin
        mv[n] = 1'b0;
      end
    end
    merr = acc && (in_sel == 2'd3);
    if (merr && mcnt < 255) mcnt++;
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [5:0] d, input logic [2:0] r);
    @(negedge clk);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    rdy      = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_sel = 2'd3; in_data = 6'h3F; rdy = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++;
    if (err_pulse !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_err_cnt: got err=%b cnt=%0d expected err=0 cnt=0", err_pulse, drop_cnt);
    end
    for (int n = 0; n < 3; n++) begin
      n_checks++;
      if (ov[n] !== 1'b0 || od[n] !== 6'h00) begin
        n_fail++; $display("FAIL reset_out ch%0d: got v=%b d=%h expected v=0 d=00", n, ov[n], od[n]);
      end
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    // Load ch1 with 2A and hold it (consumer stalled).
    drive(1'b1, 2'd1, 6'h2A, 3'b101);
    tick();
    n_checks++;
    if (out1_valid !== 1'b1 || out1_data !== 6'h2A) begin
      n_fail++; $display("FAIL reset_preload: got v=%b d=%h expected v=1 d=2a", out1_valid, out1_data);
    end
    // Assert reset mid-cycle with a word still presented.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (out1_valid !== 1'b0 || out1_data !== 6'h00 || drop_cnt !== 8'd0 || err_pulse !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b d=%h cnt=%0d err=%b rdy=%b expected v=0 d=00 cnt=0 err=0 rdy=0",
               out1_valid, out1_data, drop_cnt, err_pulse, in_ready);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int n = 0; n < 3; n++) begin
        n_checks++;
        if (ov[n] !== 1'b0) begin n_fail++; $display("FAIL reset_idle ch%0d cyc%0d: got v=%b expected 0", n, c, ov[n]); end
      end
    end
  endtask

  task automatic test_routing();
    logic [5:0] words [3];
    words[0] = 6'h15; words[1] = 6'h2A; words[2] = 6'h3F;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'(k), words[k], 3'b111);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL route_in_ready w%0d: got %b expected 1", k, in_ready); end
      tick();
      n_checks++;
      if (ov[k] !== 1'b1 || od[k] !== words[k]) begin
        n_fail++; $display("FAIL route_out ch%0d: got v=%b d=%h expected v=1 d=%h", k, ov[k], od[k], words[k]);
      end
      for (int n = 0; n < 3; n++) begin
        n_checks++;
        if (ov[n] !== mv[n]) begin n_fail++; $display("FAIL route_valid ch%0d: got %b expected %b", n, ov[n], mv[n]); end
      end
    end
    drive(1'b0, 2'd0, 6'h00, 3'b111);
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 2'd1, 6'h01, 3'b101);
    tick();
    drive(1'b1, 2'd0, 6'h03, 3'b101);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_other_ready: got %b expected 1", in_ready); end
    tick();
    n_checks++;
    if (out0_valid !== 1'b1 || out0_data !== 6'h03) begin
      n_fail++; $display("FAIL bp_other_out: got v=%b d=%h expected v=1 d=03", out0_valid, out0_data);
    end
    drive(1'b1, 2'd1, 6'h02, 3'b101);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready: got %b expected 0", in_ready); end
    tick();
    n_checks++;
    if (out1_valid !== 1'b1 || out1_data !== 6'h01) begin
      n_fail++; $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=01", out1_valid, out1_data);
    end
    drive(1'b1, 2'd1, 6'h02, 3'b111);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    tick();
    n_checks++;
    if (out1_valid !== 1'b1 || out1_data !== 6'h02) begin
      n_fail++; $display("FAIL bp_replace: got v=%b d=%h expected v=1 d=02", out1_valid, out1_data);
    end
    drive(1'b0, 2'd0, 6'h00, 3'b111);
    tick();
  endtask

  task automatic test_drain_load();
    drive(1'b1, 2'd2, 6'h10, 3'b011);
    tick();
    drive(1'b1, 2'd2, 6'h11, 3'b111);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dl_in_ready: got %b expected 1", in_ready); end
    tick();
    n_checks++;
    if (out2_valid !== 1'b1 || out2_data !== 6'h11) begin
      n_fail++; $display("FAIL dl_out: got v=%b d=%h expected v=1 d=11", out2_valid, out2_data);
    end
    drive(1'b0, 2'd0, 6'h00, 3'b111);
    tick();
  endtask

  task automatic test_invalid();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'd3, 6'(k + 7), 3'b111);
      tick();
      n_checks++;
      if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL inv_err w%0d: got %b expected 1", k, err_pulse); end
      for (int n = 0; n < 3; n++) begin
        n_checks++;
        if (ov[n] !== 1'b0) begin n_fail++; $display("FAIL inv_valid ch%0d: got %b expected 0", n, ov[n]); end
      end
    end
    n_checks++;
    if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL inv_cnt: got %0d expected 3", drop_cnt); end
    drive(1'b0, 2'd3, 6'h00, 3'b111);
    tick();
    n_checks++;
    if (err_pulse !== 1'b0 || drop_cnt !== 8'd3) begin
      n_fail++; $display("FAIL inv_after: got err=%b cnt=%0d expected err=0 cnt=3", err_pulse, drop_cnt);
    end
  endtask

  task automatic test_random();
    bit held;
    held = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (held) drive(in_valid, in_sel, in_data, 3'($urandom));
      else drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 6'($urandom), 3'($urandom));
      n_checks++;
      if (in_ready !== m_ready()) begin
        n_fail++; $display("FAIL rnd_in_ready cyc%0d: got %b expected %b", c, in_ready, m_ready());
      end
      held = in_valid && !m_ready();
      tick();
      for (int n = 0; n < 3; n++) begin
        n_checks++;
        if (ov[n] !== mv[n] || (mv[n] && od[n] !== md[n])) begin
          n_fail++; $display("FAIL rnd_out ch%0d cyc%0d: got v=%b d=%h expected v=%b d=%h", n, c, ov[n], od[n], mv[n], md[n]);
        end
      end
      n_checks++;
      if (err_pulse !== merr || drop_cnt !== 8'(mcnt)) begin
        n_fail++; $display("FAIL rnd_err cyc%0d: got err=%b cnt=%0d expected err=%b cnt=%0d", c, err_pulse, drop_cnt, merr, mcnt);
      end
    end
    drive(1'b0, 2'd0, 6'h00, 3'b111);
    tick();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 260; k++) begin
      drive(1'b1, 2'd3, 6'($urandom), 3'b111);
      tick();
      n_checks++;
      if (err_pulse !== 1'b1 || drop_cnt !== 8'(mcnt)) begin
        n_fail++; $display("FAIL sat_step w%0d: got err=%b cnt=%0d expected err=1 cnt=%0d", k, err_pulse, drop_cnt, mcnt);
      end
    end
    n_checks++;
    if (drop_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_final: got %h expected ff", drop_cnt); end
    drive(1'b0, 2'd0, 6'h00, 3'b111);
    tick();
    n_checks++;
    if (drop_cnt !== 8'hFF || err_pulse !== 1'b0) begin
      n_fail++; $display("FAIL sat_hold: got cnt=%h err=%b expected cnt=ff err=0", drop_cnt, err_pulse);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_drain_load();
    test_invalid();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/six_bit_one_to_three_demux_reg_module.md
Name: six_bit_one_to_three_demux_reg_module

Overview:
- Inverse of the team's 6-bit 3:1 select path. Takes one 6-bit word plus a 2-bit select and steers it to one of three registered output channels.
- Every port uses valid/ready. Each output channel holds one word, so a stalled consumer only blocks its own traffic.
- Sits between the datapath result bus and the three downstream consumers (register-file write port, memory-write port, output port).

Parameters:
- WIDTH, 6, data width per word.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination select: 0 = ch0, 1 = ch1, 2 = ch2, 3 = invalid.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  word accepted this cycle when in_valid is also high.
- out0_data, out1_data, out2_data  output  WIDTH each  channel data.
- out0_valid, out1_valid, out2_valid  output  1 each  channel holds a word.
- out0_ready, out1_ready, out2_ready  input  1 each  consumer takes the word.
- err_pulse  output  1  one-cycle pulse one cycle after a sel=3 word is accepted.
- drop_cnt  output  CNT_W  count of sel=3 words dropped, saturating.

Behaviour:
- Reset: asynchronous, active-high. Clock and reset are the single clk and reset above; polarity and synchronicity are fixed.
- Values while reset is high (outputs and state):
  - all outN_valid = 0, all outN_data = 0;
  - err_pulse = 0, drop_cnt = 0;
  - in_ready = 0.
- Reset mid-operation discards any held words. No output fires on the cycle reset deasserts. Normal operation starts on the first clk edge after deassertion.
- Handshakes:
  - Transfer on the input: in_valid & in_ready at the clk edge.
  - Transfer on channel N: outN_valid & outN_ready at the clk edge.
- in_ready is combinational on in_sel and the target slot:
  - sel 0..2: in_ready = !outN_valid | outN_ready for the selected N, so a full slot accepts new data in the same cycle it is drained.
  - sel = 3: in_ready = 1; the word is always dropped.
- in_ready must not depend on in_valid. in_sel and in_data must stay stable while in_valid is high and in_ready is low; this is a requirement on the upstream block.
- Latency:
  - A word accepted at edge k appears on outN_data/outN_valid after edge k (visible in cycle k+1).
  - No combinational path from in_data to any outN_data.
- Each channel slot is a one-entry register:
  - load when an input transfer targets it;
  - clear valid when drained with no simultaneous load;
  - load + drain in the same cycle: valid stays 1 and data is replaced.
  - Unselected slots keep their value, so out data is stable while valid is high and not drained.
- Independence: a stalled channel (ready low) blocks only inputs whose in_sel selects it. Inputs to the other channels flow at full rate, one word per cycle.
- Invalid select (sel = 3), when accepted:
  - err_pulse = 1 for exactly the next cycle;
  - drop_cnt increments by 1 and saturates at 2^CNT_W - 1 (255), with no wrap.
  - Back-to-back sel=3 words hold err_pulse high for consecutive cycles.
- Throughput: one input word per cycle maximum. At most one slot loads per cycle; any number of slots may drain in the same cycle.
- in_valid low: no slot loads and the counters hold.

Decomposition:
- Shared defines file:
  - SEL_CH0 = 2'd0, SEL_CH1 = 2'd1, SEL_CH2 = 2'd2, SEL_BAD = 2'd3;
  - WIDTH default 6.
- One sub-module, six_bit_out_slot_module, instantiated three times.
  - Ports: clk, reset, load, load_data[WIDTH], ready, valid, data.
  - Holds the one-entry valid/data register and its load/drain rules.
- The top level holds:
  - select decode, generating load0..load2 and the drop strobe;
  - the in_ready mux;
  - the err_pulse flop and the saturating drop counter.

Test Plan:
- Reset check: assert reset mid-cycle with ch1 full (data 6'h2A) -> immediately out1_valid=0, out1_data=0, drop_cnt=0, err_pulse=0, in_ready=0; after deassert, no valid rises until a new transfer.
- Routing and latency: all readys=1; send 6'h15 sel0, 6'h2A sel1, 6'h3F sel2 on consecutive cycles -> each appears on out0/out1/out2 exactly one cycle after acceptance; in_ready stays 1.
- Backpressure isolation:
  - out1_ready=0; send 6'h01 sel1, 6'h02 sel1 -> first held; in_ready=0 while the second is presented; out1_data stays 6'h01.
  - Meanwhile 6'h03 sel0 is accepted at full rate.
  - Raise out1_ready -> 6'h01 drains and 6'h02 loads on the same edge.
- Simultaneous drain and load: ch2 full with 6'h10 and out2_ready=1; present 6'h11 sel2 -> in_ready=1; next cycle out2_valid=1, out2_data=6'h11, with no bubble cycle.
- Invalid select: send 3 back-to-back sel=3 words -> err_pulse high for 3 consecutive cycles, each starting one cycle after acceptance; drop_cnt=3; no outN_valid changes.
- Saturation: send 260 sel=3 words -> drop_cnt stops at 8'hFF and stays at 8'hFF; err_pulse still pulses for every drop.
